// File: rtl/fft_mem_pkg.sv
// Shared types and defaults for the FFT scratch RAM.
package fft_mem_pkg;

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned MAX_PORTS  = 4;
  localparam int unsigned COLL_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } ram_state_t;

endpackage

// File: rtl/fft_ram_rd_pipe.sv
// Read-data pipeline for one read port: RD_LAT registered stages of data/valid.
// Each stage only reloads its data when the incoming valid is set, so the
// output data holds its last value while o_valid is low.
// Ports: clk, rstn (sync, active-low), i_valid/i_data (stage-0 input),
//        o_valid/o_data (registered pipeline output).
module fft_ram_rd_pipe #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [RD_LAT];
  logic [DATA_W-1:0] data_d [RD_LAT];

  // Shift valid every cycle; data advances only alongside a valid.
  always_comb begin
    valid_d[0] = i_valid;
    data_d[0]  = i_valid ? i_data : data_q[0];
    for (int s = 1; s < int'(RD_LAT); s++) begin
      valid_d[s] = valid_q[s-1];
      data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int s = 0; s < int'(RD_LAT); s++) data_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < int'(RD_LAT); s++) data_q[s] <= data_d[s];
    end
  end

  assign o_valid = valid_q[RD_LAT-1];
  assign o_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/fft_scratch_ram.sv
// Multi-port FFT scratchpad: NUM_RD read ports with RD_LAT-cycle latency,
// NUM_WR write ports under a global write strobe (highest port wins on an
// address clash), sticky collision / out-of-range flags, a saturating
// collision counter and a zero-fill clear engine (IDLE -> CLEAR -> DONE).
// Ports: clk, rstn (sync, active-low); i_ren/i_raddr -> o_rdata/o_rvalid;
//        i_global_write_enable/i_wmask/i_waddr/i_wdata; i_clear_start ->
//        o_busy/o_clear_done; o_wr_collision, o_addr_err, o_collision_cnt.
// Build option: define FFT_RAM_BYPASS_EN for write-first read-during-write
// (winning write data forwarded into the first read stage); otherwise read-first.
module fft_scratch_ram
  import fft_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_RD-1:0]        i_ren,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  output logic [NUM_RD-1:0]        o_rvalid,
  input  logic                     i_global_write_enable,
  input  logic [NUM_WR-1:0]        i_wmask,
  input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
  input  logic [NUM_WR*DATA_W-1:0] i_wdata,
  input  logic                     i_clear_start,
  output logic                     o_busy,
  output logic                     o_clear_done,
  output logic                     o_wr_collision,
  output logic                     o_addr_err,
  output logic [COLL_CNT_W-1:0]    o_collision_cnt
);

  // Clear pointer carries headroom so ptr + NUM_WR never wraps.
  localparam int unsigned PTR_W = ADDR_W + 2;
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  ram_state_t            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  coll_q, coll_d;
  logic                  err_q, err_d;
  logic [COLL_CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_WR-1:0] wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c [NUM_WR];
  logic [DATA_W-1:0] wr_data_c [NUM_WR];
  logic [ADDR_W-1:0] ext_addr_c [NUM_WR];
  logic [PTR_W-1:0]  clr_ptr_c [NUM_WR];
  logic              wr_err_c;
  logic              coll_c;

  logic [ADDR_W-1:0] rd_addr_c [NUM_RD];
  logic [DATA_W-1:0] rd_data_c [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_c;
  logic              rd_err_c;

  // Write-port resolution: clear engine owns the ports while clearing.
  always_comb begin
    wr_err_c = 1'b0;
    coll_c   = 1'b0;
    for (int q = 0; q < int'(NUM_WR); q++) begin
      clr_ptr_c[q]  = ptr_q + PTR_W'(q);
      ext_addr_c[q] = i_waddr[q*ADDR_W +: ADDR_W];
      if (state_q == CLEAR) begin
        wr_en_c[q]   = clr_ptr_c[q] < DEPTH_P;
        wr_addr_c[q] = clr_ptr_c[q][ADDR_W-1:0];
        wr_data_c[q] = '0;
      end else begin
        wr_en_c[q]   = i_global_write_enable && i_wmask[q] && ({1'b0, ext_addr_c[q]} < DEPTH_A);
        wr_addr_c[q] = ext_addr_c[q];
        wr_data_c[q] = i_wdata[q*DATA_W +: DATA_W];
        wr_err_c     = wr_err_c | (i_global_write_enable && i_wmask[q] &&
                                   ({1'b0, ext_addr_c[q]} >= DEPTH_A));
      end
    end
    if (state_q != CLEAR) begin
      for (int a = 0; a < int'(NUM_WR); a++) begin
        for (int b = a + 1; b < int'(NUM_WR); b++) begin
          if (wr_en_c[a] && wr_en_c[b] && (wr_addr_c[a] == wr_addr_c[b])) coll_c = 1'b1;
        end
      end
    end
  end

  // Stage-0 read data; out-of-range reads return zero but still complete.
  always_comb begin
    rd_err_c = 1'b0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      rd_addr_c[p]  = i_raddr[p*ADDR_W +: ADDR_W];
      rd_valid_c[p] = i_ren[p] && (state_q != CLEAR);
      rd_data_c[p]  = '0;
      if ({1'b0, rd_addr_c[p]} < DEPTH_A) begin
        rd_data_c[p] = mem_q[rd_addr_c[p]];
`ifdef FFT_RAM_BYPASS_EN
        // Ascending scan so the highest-index matching port wins, as in the array.
        for (int q = 0; q < int'(NUM_WR); q++) begin
          if ((state_q != CLEAR) && wr_en_c[q] && (wr_addr_c[q] == rd_addr_c[p]))
            rd_data_c[p] = wr_data_c[q];
        end
`endif
      end else begin
        rd_err_c = rd_err_c | i_ren[p];
      end
    end
  end

  // Storage array, not reset; later ports overwrite earlier ones on a clash.
  always_ff @(posedge clk) begin
    for (int q = 0; q < int'(NUM_WR); q++) begin
      if (wr_en_c[q]) mem_q[wr_addr_c[q]] <= wr_data_c[q];
    end
  end

  // Clear FSM next-state and status flags.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (i_clear_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + PTR_W'(NUM_WR);
        if (ptr_d >= DEPTH_P) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
    done_d = (state_d == DONE);
    coll_d = coll_q | coll_c;
    err_d  = err_q | wr_err_c | rd_err_c;
    cnt_d  = cnt_q;
    if (coll_c && (cnt_q != {COLL_CNT_W{1'b1}})) cnt_d = cnt_q + COLL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      coll_q  <= coll_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    fft_ram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
    ) u_rd_pipe (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (rd_valid_c[p]),
      .i_data  (rd_data_c[p]),
      .o_valid (o_rvalid[p]),
      .o_data  (o_rdata[p*DATA_W +: DATA_W])
    );
  end

  assign o_busy          = busy_q;
  assign o_clear_done    = done_q;
  assign o_wr_collision  = coll_q;
  assign o_addr_err      = err_q;
  assign o_collision_cnt = cnt_q;

endmodule

// File: tb/tb_fft_scratch_ram.sv
// Directed bench for fft_scratch_ram: default instance (256x128, 2R/2W, RD_LAT=1)
// and a DEPTH=200 / RD_LAT=3 single-port instance for range and latency cases.
module tb_fft_scratch_ram;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic [1:0]   a_ren = '0;
  logic [15:0]  a_raddr = '0;
  logic [255:0] a_rdata;
  logic [1:0]   a_rvalid;
  logic         a_gwe = 1'b0;
  logic [1:0]   a_wmask = '0;
  logic [15:0]  a_waddr = '0;
  logic [255:0] a_wdata = '0;
  logic         a_clr = 1'b0;
  logic         a_busy, a_done, a_coll, a_err;
  logic [7:0]   a_cnt;

  // DEPTH=200, RD_LAT=3 instance
  logic         b_ren = 1'b0;
  logic [7:0]   b_raddr = '0;
  logic [127:0] b_rdata;
  logic         b_rvalid;
  logic         b_gwe = 1'b0;
  logic         b_wmask = 1'b0;
  logic [7:0]   b_waddr = '0;
  logic [127:0] b_wdata = '0;
  logic         b_busy, b_done, b_coll, b_err;
  logic [7:0]   b_cnt;

  fft_scratch_ram u_dut (
    .clk(clk), .rstn(rstn),
    .i_ren(a_ren), .i_raddr(a_raddr), .o_rdata(a_rdata), .o_rvalid(a_rvalid),
    .i_global_write_enable(a_gwe), .i_wmask(a_wmask), .i_waddr(a_waddr), .i_wdata(a_wdata),
    .i_clear_start(a_clr), .o_busy(a_busy), .o_clear_done(a_done),
    .o_wr_collision(a_coll), .o_addr_err(a_err), .o_collision_cnt(a_cnt)
  );

  fft_scratch_ram #(.DEPTH(200), .NUM_RD(1), .NUM_WR(1), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rstn(rstn),
    .i_ren(b_ren), .i_raddr(b_raddr), .o_rdata(b_rdata), .o_rvalid(b_rvalid),
    .i_global_write_enable(b_gwe), .i_wmask(b_wmask), .i_waddr(b_waddr), .i_wdata(b_wdata),
    .i_clear_start(1'b0), .o_busy(b_busy), .o_clear_done(b_done),
    .o_wr_collision(b_coll), .o_addr_err(b_err), .o_collision_cnt(b_cnt)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int i);
    return 128'(i + 1) ^ {4{32'hC0DE_0000}};
  endfunction

  // Start a clear, count busy cycles and check the done pulse.
  task automatic run_clear(input bit poke);
    int n;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    n = 0;
    while (a_busy && n < 1000) begin
      if (poke && n == 10) begin
        a_gwe = 1'b1; a_wmask = 2'b01; a_waddr = 16'd0; a_wdata = {256{1'b1}};
        a_ren = 2'b01; a_raddr = 16'd7;
      end
      if (poke && n == 11) begin
        a_gwe = 1'b0; a_wmask = 2'b00; a_ren = 2'b00;
        check("rvalid_in_clear", 128'(a_rvalid), 128'(0));
      end
      n++;
      tick();
    end
    check("busy_cycles", 128'(n), 128'(128));
    check("clear_done", 128'(a_done), 128'(1));
    tick();
    check("done_pulse_end", 128'(a_done), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] or_acc;
    int vc;
    int bad;
    logic seen;

    tick(); tick();
    rstn = 1'b1;
    check("rst_rvalid", 128'(a_rvalid), 128'(0));
    check("rst_rdata", a_rdata[127:0], 128'(0));
    check("rst_flags", 128'({a_busy, a_done, a_coll, a_err}), 128'(0));
    check("rst_cnt", 128'(a_cnt), 128'(0));

    // Basic write then dual-port read
    a_gwe = 1'b1; a_wmask = 2'b01; a_waddr = 16'd7; a_wdata = {128'h0, {16{8'hA5}}};
    tick();
    a_gwe = 1'b0; a_wmask = 2'b00;
    a_ren = 2'b11; a_raddr = {8'd7, 8'd7};
    tick();
    check("rd_p0", a_rdata[127:0], {16{8'hA5}});
    check("rd_p1", a_rdata[255:128], {16{8'hA5}});
    check("rd_valid", 128'(a_rvalid), 128'(3));
    a_ren = 2'b00;
    tick();
    check("rvalid_drop", 128'(a_rvalid), 128'(0));
    check("rdata_hold", a_rdata[127:0], {16{8'hA5}});

    // Same-address collision: port 1 wins
    a_gwe = 1'b1; a_wmask = 2'b11; a_waddr = {8'd3, 8'd3};
    a_wdata = {{16{8'h22}}, {16{8'h11}}};
    tick();
    a_gwe = 1'b0; a_wmask = 2'b00;
    check("coll_flag", 128'(a_coll), 128'(1));
    check("coll_cnt1", 128'(a_cnt), 128'(1));
    a_ren = 2'b01; a_raddr = 16'd3;
    tick();
    a_ren = 2'b00;
    check("coll_winner", a_rdata[127:0], {16{8'h22}});

    // Read-during-write on addr 9
    a_gwe = 1'b1; a_wmask = 2'b01; a_waddr = 16'd9; a_wdata = {128'h0, {16{8'h0F}}};
    tick();
    a_wdata = {128'h0, {16{8'hF0}}};
    a_ren = 2'b01; a_raddr = 16'd9;
    tick();
    a_gwe = 1'b0; a_wmask = 2'b00;
`ifdef FFT_RAM_BYPASS_EN
    check("rdw", a_rdata[127:0], {16{8'hF0}});
`else
    check("rdw", a_rdata[127:0], {16{8'h0F}});
`endif
    tick();
    a_ren = 2'b00;
    check("rdw_after", a_rdata[127:0], {16{8'hF0}});
    check("no_err_default", 128'(a_err), 128'(0));

    // 300 more collisions saturate the counter
    a_gwe = 1'b1; a_wmask = 2'b11; a_waddr = {8'd5, 8'd5};
    repeat (300) tick();
    a_gwe = 1'b0; a_wmask = 2'b00;
    check("coll_sat", 128'(a_cnt), 128'(255));

    // Full clear with a write/read issued while busy
    run_clear(1'b1);
    or_acc = '0;
    vc = 0;
    for (int i = 0; i < 128; i++) begin
      a_ren = 2'b11;
      a_raddr = {8'(2*i+1), 8'(2*i)};
      tick();
      or_acc = or_acc | a_rdata;
      if (a_rvalid == 2'b11) vc++;
    end
    a_ren = 2'b00;
    check("clear_zero", or_acc[127:0] | or_acc[255:128], 128'(0));
    check("clear_rd_valid", 128'(vc), 128'(128));

    // Reset in the middle of a clear
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    repeat (40) tick();
    check("busy_mid", 128'(a_busy), 128'(1));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_rst_busy", 128'(a_busy), 128'(0));
    check("mid_rst_done", 128'(a_done), 128'(0));
    check("mid_rst_sticky", 128'({a_coll, a_err, a_cnt}), 128'(0));
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | a_done | a_busy;
    end
    check("mid_rst_idle", 128'(seen), 128'(0));
    run_clear(1'b0);

    // DEPTH=200 / RD_LAT=3 instance
    b_gwe = 1'b1; b_wmask = 1'b1; b_waddr = 8'd199; b_wdata = {8{16'hBEEF}};
    tick();
    b_gwe = 1'b0; b_wmask = 1'b0;
    check("b_err_clean", 128'(b_err), 128'(0));
    b_ren = 1'b1; b_raddr = 8'd199;
    tick();
    b_ren = 1'b0;
    check("b_lat1", 128'(b_rvalid), 128'(0));
    tick();
    check("b_lat2", 128'(b_rvalid), 128'(0));
    tick();
    check("b_lat3_valid", 128'(b_rvalid), 128'(1));
    check("b_lat3_data", b_rdata, {8{16'hBEEF}});

    b_gwe = 1'b1; b_wmask = 1'b1; b_waddr = 8'd250; b_wdata = {128{1'b1}};
    tick();
    b_gwe = 1'b0; b_wmask = 1'b0;
    check("b_wr_oor_err", 128'(b_err), 128'(1));
    b_ren = 1'b1; b_raddr = 8'd250;
    tick();
    b_ren = 1'b0;
    tick(); tick();
    check("b_rd_oor_valid", 128'(b_rvalid), 128'(1));
    check("b_rd_oor_data", b_rdata, 128'(0));

    for (int i = 0; i < 200; i++) begin
      b_gwe = 1'b1; b_wmask = 1'b1; b_waddr = 8'(i); b_wdata = pat(i);
      tick();
    end
    b_gwe = 1'b0; b_wmask = 1'b0;
    vc = 0;
    bad = 0;
    for (int c = 0; c < 202; c++) begin
      if (c < 200) begin
        b_ren = 1'b1; b_raddr = 8'(c);
      end else begin
        b_ren = 1'b0;
      end
      tick();
      if (c >= 2) begin
        if (b_rvalid) vc++;
        if (b_rdata !== pat(c - 2)) bad++;
      end
    end
    check("stream_valid", 128'(vc), 128'(200));
    check("stream_data", 128'(bad), 128'(0));
    tick();
    check("stream_end", 128'(b_rvalid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
